tlp_frame_norm: RTL and testbench



---
 rtl/tlp_frame_norm.sv | 155 +++++++++++++++
 tb/tb_tlp_frame_norm.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlp_frame_norm.sv
// ============================================================================
// Module   : tlp_frame_norm
// Purpose  : Store-and-forward normaliser that turns captured PCIe TLPs into
//            fixed TLP_BEATS-beat records (zero-padded or truncated).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tlp_frame_norm #(
    parameter int TLP_BEATS = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk156,
    input  logic             sys_rst_n,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic [63:0]      s_axis_tdata,
    input  logic [7:0]       s_axis_tkeep,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic             wr_en,
    output logic [73:0]      din,
    input  logic             prog_full,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] trunc_cnt,
    output logic [CNT_W-1:0] pad_cnt
);

    localparam int IDX_W  = (TLP_BEATS > 1) ? $clog2(TLP_BEATS) : 1;
    localparam int WCNT_W = $clog2(TLP_BEATS + 1);

    localparam logic [IDX_W-1:0]  c_last_idx  = IDX_W'(TLP_BEATS - 1);
    localparam logic [WCNT_W-1:0] c_beats     = WCNT_W'(TLP_BEATS);
    localparam logic [WCNT_W-1:0] c_last_word = WCNT_W'(TLP_BEATS - 1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_DROP    = 2'd1,
        S_FLUSH   = 2'd2
    } state_t;

    state_t            r_state;
    logic [63:0]       r_buf [TLP_BEATS];
    logic [IDX_W-1:0]  r_idx;
    logic [WCNT_W-1:0] r_wcnt;
    logic              r_burst;
    logic              r_err;

    logic              w_accept;
    logic [63:0]       w_data_masked;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_rd_last;
    logic [73:0]       w_word;

    assign w_accept = s_axis_tvalid & s_axis_tready;

    generate
        for (genvar b = 0; b < 8; b++) begin : g_mask
            assign w_data_masked[8*b +: 8] = s_axis_tkeep[b] ? s_axis_tdata[8*b +: 8] : 8'h00;
        end
    endgenerate

    // Only the stored data varies; keep, tlast and tuser are rebuilt on read.
    assign w_rd_idx  = r_wcnt[IDX_W-1:0];
    assign w_rd_last = (r_wcnt == c_last_word);
    assign w_word    = {8'hFF, r_buf[w_rd_idx], w_rd_last, w_rd_last & r_err};

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state       <= S_COLLECT;
            r_idx         <= '0;
            r_wcnt        <= '0;
            r_burst       <= 1'b0;
            r_err         <= 1'b0;
            s_axis_tready <= 1'b0;
            wr_en         <= 1'b0;
            din           <= '0;
            pkt_cnt       <= '0;
            trunc_cnt     <= '0;
            pad_cnt       <= '0;
            for (int i = 0; i < TLP_BEATS; i++) r_buf[i] <= '0;
        end else begin
            wr_en <= 1'b0;
            din   <= '0;
            case (r_state)
                S_COLLECT: begin
                    s_axis_tready <= 1'b1;
                    if (w_accept) begin
                        r_buf[r_idx] <= w_data_masked;
                        r_err        <= r_err | s_axis_tuser;
                        if (r_idx == c_last_idx) begin
                            r_idx <= '0;
                            if (s_axis_tlast) begin
                                r_state       <= S_FLUSH;
                                s_axis_tready <= 1'b0;
                            end else begin
                                r_state <= S_DROP;
                                if (trunc_cnt != '1) trunc_cnt <= trunc_cnt + CNT_W'(1);
                            end
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                            if (s_axis_tlast) begin
                                r_state       <= S_FLUSH;
                                s_axis_tready <= 1'b0;
                                if (pad_cnt != '1) pad_cnt <= pad_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                S_DROP: begin
                    s_axis_tready <= 1'b1;
                    if (w_accept) begin
                        r_err <= r_err | s_axis_tuser;
                        if (s_axis_tlast) begin
                            r_state       <= S_FLUSH;
                            s_axis_tready <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    s_axis_tready <= 1'b0;
                    if (!r_burst) begin
                        // prog_full low guarantees room for the whole record.
                        if (!prog_full) begin
                            r_burst <= 1'b1;
                            wr_en   <= 1'b1;
                            din     <= w_word;
                            r_wcnt  <= r_wcnt + WCNT_W'(1);
                        end
                    end else if (r_wcnt != c_beats) begin
                        wr_en  <= 1'b1;
                        din    <= w_word;
                        r_wcnt <= r_wcnt + WCNT_W'(1);
                    end else begin
                        r_burst       <= 1'b0;
                        r_wcnt        <= '0;
                        r_idx         <= '0;
                        r_err         <= 1'b0;
                        r_state       <= S_COLLECT;
                        s_axis_tready <= 1'b1;
                        if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + CNT_W'(1);
                        for (int i = 0; i < TLP_BEATS; i++) r_buf[i] <= '0;
                    end
                end
                default: begin
                    r_state <= S_COLLECT;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tlp_frame_norm.sv
// ============================================================================
// Module   : tb_tlp_frame_norm
// Purpose  : Scoreboard bench for tlp_frame_norm record normalisation.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tlp_frame_norm;

    localparam int NB = 4;

    logic        clk156 = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic        wr_en;
    logic [73:0] din;
    logic        prog_full = 1'b0;
    logic [15:0] pkt_cnt, trunc_cnt, pad_cnt;

    int errors = 0;
    int checks = 0;
    int exp_pkt = 0, exp_pad = 0, exp_trunc = 0;
    logic [73:0] q[$];
    logic [63:0] td [16];
    logic [7:0]  tk [16];
    logic        tu [16];

    tlp_frame_norm #(.TLP_BEATS(NB), .CNT_W(16)) dut (
        .clk156       (clk156),
        .sys_rst_n    (sys_rst_n),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .wr_en        (wr_en),
        .din          (din),
        .prog_full    (prog_full),
        .pkt_cnt      (pkt_cnt),
        .trunc_cnt    (trunc_cnt),
        .pad_cnt      (pad_cnt)
    );

    always #5 clk156 = ~clk156;

    function automatic logic [63:0] mask_bytes(input logic [63:0] d, input logic [7:0] k);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = k[b] ? d[8*b +: 8] : 8'h00;
        return r;
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                             input logic l, input logic u, output bit immediate);
        int guard;
        guard = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        immediate = (s_axis_tready === 1'b1);
        while (s_axis_tready !== 1'b1 && guard < 100) begin
            @(negedge clk156);
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("FAIL beat_accept: tready=%b after %0d cycles, required 1", s_axis_tready, guard);
        end
        @(negedge clk156);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    // Pushes the expected record, then drives n beats with gap idle cycles between them.
    task automatic send_tlp(input int n, input int gap);
        logic        err;
        logic [63:0] d;
        int          stalls;
        bit          imm;
        err = 1'b0;
        stalls = 0;
        for (int i = 0; i < n; i++) err = err | tu[i];
        for (int i = 0; i < NB; i++) begin
            d = (i < n) ? mask_bytes(td[i], tk[i]) : 64'h0;
            q.push_back({8'hFF, d, (i == NB-1), (i == NB-1) & err});
        end
        exp_pkt++;
        if (n < NB) exp_pad++;
        else if (n > NB) exp_trunc++;
        for (int i = 0; i < n; i++) begin
            send_beat(td[i], tk[i], (i == n-1), tu[i], imm);
            if (i > 0 && !imm) stalls++;
            if (gap > 0 && i < n-1) repeat (gap) @(negedge clk156);
        end
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL input_stall: %0d beats waited for tready, required 0", stalls);
        end
    endtask

    task automatic collect_record(input bit pf_mid, output int waited);
        logic [73:0] exp;
        waited = 0;
        @(negedge clk156);
        while (wr_en !== 1'b1 && waited < 200) begin
            waited++;
            @(negedge clk156);
        end
        checks++;
        if (waited >= 200) begin
            errors++;
            $display("FAIL record_start: wr_en=%b after %0d cycles, required 1", wr_en, waited);
            return;
        end
        for (int w = 0; w < NB; w++) begin
            if (w > 0) @(negedge clk156);
            exp = (q.size() > 0) ? q.pop_front() : '0;
            checks++;
            if (wr_en !== 1'b1 || din !== exp) begin
                errors++;
                $display("FAIL word%0d: wr_en=%b din=%h, required wr_en=1 din=%h", w, wr_en, din, exp);
            end
            if (w == 0 && pf_mid) prog_full = 1'b1;
        end
        @(negedge clk156);
        checks++;
        if (wr_en !== 1'b0 || s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL post_burst: wr_en=%b tready=%b, required 0/1", wr_en, s_axis_tready);
        end
    endtask

    task automatic check_counters(input string tag);
        checks++;
        if (pkt_cnt !== 16'(exp_pkt)) begin
            errors++;
            $display("FAIL %s pkt_cnt: got %0d, required %0d", tag, pkt_cnt, exp_pkt);
        end
        checks++;
        if (pad_cnt !== 16'(exp_pad)) begin
            errors++;
            $display("FAIL %s pad_cnt: got %0d, required %0d", tag, pad_cnt, exp_pad);
        end
        checks++;
        if (trunc_cnt !== 16'(exp_trunc)) begin
            errors++;
            $display("FAIL %s trunc_cnt: got %0d, required %0d", tag, trunc_cnt, exp_trunc);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk156);
        checks++;
        if (wr_en !== 1'b0 || din !== 74'h0 || s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: wr_en=%b din=%h tready=%b, required 0/0/0", wr_en, din, s_axis_tready);
        end
        check_counters("reset");
        sys_rst_n = 1'b1;
        @(negedge clk156);
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_tready: got %b, required 1", s_axis_tready);
        end
    endtask

    task automatic test_full_tlp();
        int w;
        for (int i = 0; i < NB; i++) begin
            td[i] = 64'hA5A5_5A5A_0123_4567;
            tk[i] = 8'hFF;
            tu[i] = 1'b0;
        end
        send_tlp(4, 0);
        collect_record(1'b0, w);
        check_counters("full");
    endtask

    task automatic test_pad();
        int w;
        td[0] = 64'hDEAD_BEEF_CAFE_F00D; tk[0] = 8'hFF; tu[0] = 1'b0;
        td[1] = 64'h1122_3344_5566_7788; tk[1] = 8'h0F; tu[1] = 1'b0;
        send_tlp(2, 0);
        collect_record(1'b0, w);
        check_counters("pad");
    endtask

    task automatic test_trunc();
        int w;
        for (int i = 0; i < 7; i++) begin
            td[i] = 64'h1000_0000_0000_0000 + 64'(i * 64'h0101_0101);
            tk[i] = 8'hFF;
            tu[i] = (i == 5);
        end
        tk[1] = 8'hF0;
        tk[2] = 8'h00;
        send_tlp(7, 0);
        collect_record(1'b0, w);
        check_counters("trunc");
    endtask

    task automatic test_prog_full();
        int w;
        for (int i = 0; i < NB; i++) begin
            td[i] = {$urandom, $urandom};
            tk[i] = 8'hFF;
            tu[i] = 1'b0;
        end
        prog_full = 1'b1;
        send_tlp(4, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk156);
            checks++;
            if (wr_en !== 1'b0 || s_axis_tready !== 1'b0) begin
                errors++;
                $display("FAIL pf_hold cyc%0d: wr_en=%b tready=%b, required 0/0", c, wr_en, s_axis_tready);
            end
        end
        prog_full = 1'b0;
        collect_record(1'b1, w);
        checks++;
        if (w != 0) begin
            errors++;
            $display("FAIL pf_release_latency: %0d extra cycles, required 0", w);
        end
        prog_full = 1'b0;
        check_counters("prog_full");
    endtask

    task automatic test_bubbles();
        int w;
        for (int i = 0; i < NB; i++) begin
            td[i] = {$urandom, $urandom};
            tk[i] = 8'(8'h0F << i);
            tu[i] = 1'b0;
        end
        send_tlp(4, 3);
        collect_record(1'b0, w);
        check_counters("bubbles");
    endtask

    task automatic test_back_to_back();
        int w, n, start_pkt;
        start_pkt = exp_pkt;
        for (int t = 0; t < 8; t++) begin
            n = 1 + (t % 6);
            for (int i = 0; i < n; i++) begin
                td[i] = {$urandom, $urandom};
                tk[i] = 8'($urandom_range(0, 255));
                tu[i] = ($urandom_range(0, 7) == 0);
            end
            send_tlp(n, 0);
            collect_record(1'b0, w);
        end
        checks++;
        if (q.size() != 0 || exp_pkt - start_pkt != 8) begin
            errors++;
            $display("FAIL b2b_scoreboard: %0d words left, required 0", q.size());
        end
        check_counters("back_to_back");
    endtask

    task automatic test_reset_mid_burst();
        int guard, w;
        logic [73:0] exp;
        for (int i = 0; i < NB; i++) begin
            td[i] = {$urandom, $urandom};
            tk[i] = 8'hFF;
            tu[i] = 1'b0;
        end
        send_tlp(4, 0);
        guard = 0;
        @(negedge clk156);
        while (wr_en !== 1'b1 && guard < 100) begin
            guard++;
            @(negedge clk156);
        end
        for (int wd = 0; wd < 2; wd++) begin
            if (wd > 0) @(negedge clk156);
            exp = (q.size() > 0) ? q.pop_front() : '0;
            checks++;
            if (wr_en !== 1'b1 || din !== exp) begin
                errors++;
                $display("FAIL rst_burst word%0d: wr_en=%b din=%h, required wr_en=1 din=%h", wd, wr_en, din, exp);
            end
        end
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_async_wr_en: got %b, required 0", wr_en);
        end
        q.delete();
        exp_pkt = 0;
        exp_pad = 0;
        exp_trunc = 0;
        check_counters("mid_reset");
        @(negedge clk156);
        sys_rst_n = 1'b1;
        @(negedge clk156);
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_tready: got %b, required 1", s_axis_tready);
        end
        for (int i = 0; i < NB; i++) td[i] = {$urandom, $urandom};
        send_tlp(4, 0);
        collect_record(1'b0, w);
        check_counters("after_reset");
    endtask

    initial begin
        test_reset();
        test_full_tlp();
        test_pad();
        test_trunc();
        test_prog_full();
        test_bubbles();
        test_back_to_back();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
